// File: rtl/seq_pkg.sv
// Shared FSM state type and sizing helpers for the bit serializer.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  // Bit-counter width; never narrower than one bit, even for 2-bit words.
  function automatic int cnt_width(input int data_w);
    return (data_w <= 2) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable parallel-in/serial-out shifter. It stores only the bits still to come;
// the first bit of a word is handed straight to the caller through o_first.
module piso_shift_reg
  import seq_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_first,
  output logic              o_head
);

  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_shift_val;

  generate
    if (MSB_FIRST) begin : g_msb
      assign o_first     = i_data[DATA_W-1];
      assign o_head      = r_shift[DATA_W-1];
      assign w_load_val  = {i_data[DATA_W-2:0], 1'b0};
      assign w_shift_val = {r_shift[DATA_W-2:0], 1'b0};
    end else begin : g_lsb
      assign o_first     = i_data[0];
      assign o_head      = r_shift[0];
      assign w_load_val  = {1'b0, i_data[DATA_W-1:1]};
      assign w_shift_val = {1'b0, r_shift[DATA_W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= w_load_val;
    end else if (i_shift) begin
      r_shift <= w_shift_val;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit serializer: one shifter plus one holding register, giving
// back-to-back words on ser_out with every output driven from a flop.
module bit_serializer
  import seq_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              word_done,
  output logic              busy
);

  localparam int               CNT_W        = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(DATA_W - 2);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic              r_ready;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic              r_word_done;
  logic              r_busy;

  logic              w_accept;
  logic              w_last;
  logic              w_load;
  logic              w_shift;
  logic              w_direct;
  logic              w_hold_wr;
  logic              w_hold_full_next;
  logic              w_first;
  logic              w_head;
  logic [DATA_W-1:0] w_load_data;

  assign w_accept = s_valid & r_ready;
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_CNT);

  // An empty or finishing shifter takes the held word first, otherwise a word arriving now.
  assign w_load      = ((r_state == IDLE) || w_last) && (r_hold_full || w_accept);
  assign w_shift     = (r_state == SHIFT) && !w_last;
  assign w_direct    = w_load && !r_hold_full;
  assign w_hold_wr   = w_accept && !w_direct;
  assign w_load_data = r_hold_full ? r_hold : s_data;

  assign w_hold_full_next = w_hold_wr ? 1'b1 :
                            (w_load && r_hold_full) ? 1'b0 : r_hold_full;

  piso_shift_reg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_first (w_first),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ready     <= 1'b0;
      r_ser_out   <= IDLE_BIT;
      r_ser_valid <= 1'b0;
      r_word_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_hold_wr) begin
        r_hold <= s_data;
      end
      r_hold_full <= w_hold_full_next;
      r_ready     <= !w_hold_full_next;
      r_busy      <= w_load || w_shift || w_hold_full_next;

      if (w_load) begin
        r_state     <= SHIFT;
        r_cnt       <= '0;
        r_ser_out   <= w_first;
        r_ser_valid <= 1'b1;
        r_word_done <= (LAST_CNT == '0);
      end else if (w_shift) begin
        r_state     <= SHIFT;
        r_cnt       <= r_cnt + 1'b1;
        r_ser_out   <= w_head;
        r_ser_valid <= 1'b1;
        r_word_done <= (r_cnt == PRE_LAST_CNT);
      end else begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_ser_out   <= IDLE_BIT;
        r_ser_valid <= 1'b0;
        r_word_done <= 1'b0;
      end
    end
  end

  assign s_ready   = r_ready;
  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign word_done = r_word_done;
  assign busy      = r_busy;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: default MSB-first build, an LSB-first build
// feeding a 1010 detector model, and an IDLE_BIT=1 build left without input.
module tb_bit_serializer;

  logic       clk;
  logic       rst;

  logic       sValid;
  logic [7:0] sData;
  logic       sReady, serOut, serValid, wordDone, busy;

  logic       lsbValid;
  logic [7:0] lsbData;
  logic       lsbReady, lsbSerOut, lsbSerValid, lsbWordDone, lsbBusy;

  logic       idlValid;
  logic [7:0] idlData;
  logic       idlReady, idlSerOut, idlSerValid, idlWordDone, idlBusy;

  int         checkCount;
  int         failCount;

  logic [7:0] srcWords [3];
  int         srcIdx;
  int         srcCount;

  bit_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (sValid),
    .s_data    (sData),
    .s_ready   (sReady),
    .ser_out   (serOut),
    .ser_valid (serValid),
    .word_done (wordDone),
    .busy      (busy)
  );

  bit_serializer #(.MSB_FIRST(1'b0)) dutLsb (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (lsbValid),
    .s_data    (lsbData),
    .s_ready   (lsbReady),
    .ser_out   (lsbSerOut),
    .ser_valid (lsbSerValid),
    .word_done (lsbWordDone),
    .busy      (lsbBusy)
  );

  bit_serializer #(.IDLE_BIT(1'b1)) dutIdle1 (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (idlValid),
    .s_data    (idlData),
    .s_ready   (idlReady),
    .ser_out   (idlSerOut),
    .ser_valid (idlSerValid),
    .word_done (idlWordDone),
    .busy      (idlBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int count, input logic [7:0] w0,
                               input logic [7:0] w1, input logic [7:0] w2);
    srcWords[0] = w0;
    srcWords[1] = w1;
    srcWords[2] = w2;
    srcIdx      = 0;
    srcCount    = count;
    sData       = w0;
    sValid      = 1'b1;
  endtask

  // Advance one cycle; the source moves to its next word only after a real handshake.
  task automatic tick();
    logic accepted;
    accepted = sValid && sReady;
    @(posedge clk);
    #1;
    if (accepted) begin
      srcIdx++;
      if (srcIdx < srcCount) sData = srcWords[srcIdx];
      else sValid = 1'b0;
    end
  endtask

  // First sample lands in the most significant position of each n-bit field.
  task automatic captureWindow(input int n, output logic [31:0] bits,
                               output logic [31:0] valids, output logic [31:0] dones,
                               output logic [31:0] readys, output logic [31:0] busys);
    bits = '0; valids = '0; dones = '0; readys = '0; busys = '0;
    for (int i = 0; i < n; i++) begin
      bits   = {bits[30:0], serOut};
      valids = {valids[30:0], serValid};
      dones  = {dones[30:0], wordDone};
      readys = {readys[30:0], sReady};
      busys  = {busys[30:0], busy};
      tick();
    end
  endtask

  initial begin
    logic [31:0] bits, valids, dones, readys, busys;
    logic [3:0]  hist;
    int          nValid;
    int          detCount;
    logic        allOne;
    logic        anyActive;

    checkCount = 0;
    failCount  = 0;
    rst        = 1'b0;
    sValid     = 1'b0;
    sData      = '0;
    lsbValid   = 1'b0;
    lsbData    = '0;
    idlValid   = 1'b0;
    idlData    = '0;
    srcIdx     = 0;
    srcCount   = 0;

    @(posedge clk);
    #1;
    checkOutput("reset_outputs", 32'({sReady, serOut, serValid, wordDone, busy}), 0);
    checkOutput("reset_idle_bit_one", 32'({idlSerOut, idlSerValid}), 'h2);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ready_low_in_reset", 32'(sReady), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_release", 32'(sReady), 1);
    checkOutput("idle_after_release", 32'({serOut, serValid, wordDone, busy}), 0);

    // Single word 0xA0, MSB first, followed by one idle cycle.
    applyStimulus(1, 8'hA0, 8'h00, 8'h00);
    tick();
    checkOutput("a0_accepted", 32'(srcIdx), 1);
    captureWindow(9, bits, valids, dones, readys, busys);
    checkOutput("a0_bits", bits, 'h140);
    checkOutput("a0_valid", valids, 'h1FE);
    checkOutput("a0_done", dones, 'h002);
    checkOutput("a0_busy", busys, 'h1FE);
    checkOutput("a0_ready", readys, 'h1FF);

    // 0xAA then 0x55 back to back: holding register full for one window.
    applyStimulus(2, 8'hAA, 8'h55, 8'h00);
    tick();
    captureWindow(17, bits, valids, dones, readys, busys);
    checkOutput("b2b_bits", bits, 'h154AA);
    checkOutput("b2b_valid", valids, 'h1FFFE);
    checkOutput("b2b_done", dones, 'h202);
    checkOutput("b2b_ready", readys, 'h101FF);
    checkOutput("b2b_busy", busys, 'h1FFFE);
    checkOutput("b2b_accepted", 32'(srcIdx), 2);

    // Three words offered continuously; the third waits for s_ready to rise.
    applyStimulus(3, 8'hAA, 8'h55, 8'hC3);
    tick();
    captureWindow(25, bits, valids, dones, readys, busys);
    checkOutput("three_bits", bits, 'h154AB86);
    checkOutput("three_valid", valids, 'h1FFFFFE);
    checkOutput("three_done", dones, 'h20202);
    checkOutput("three_ready", readys, 'h10101FF);
    checkOutput("three_accepted", 32'(srcIdx), 3);

    // Reset in the middle of 0xF0 must drop the rest of the word.
    applyStimulus(1, 8'hF0, 8'h00, 8'h00);
    tick();
    captureWindow(3, bits, valids, dones, readys, busys);
    checkOutput("f0_first_bits", bits, 'h7);
    rst      = 1'b0;
    sValid   = 1'b0;
    srcCount = 0;
    #2;
    checkOutput("reset_mid_word", 32'({sReady, serOut, serValid, wordDone, busy}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    checkOutput("ready_after_mid_reset", 32'(sReady), 1);
    captureWindow(10, bits, valids, dones, readys, busys);
    checkOutput("no_residual_bits", bits, 0);
    checkOutput("no_residual_valid", valids, 0);
    checkOutput("no_residual_busy", busys, 0);

    // LSB-first build, word 0x05, watched by a 1010 detector model.
    lsbValid = 1'b1;
    lsbData  = 8'h05;
    @(posedge clk);
    #1;
    lsbValid = 1'b0;
    bits = '0; dones = '0; hist = '0; nValid = 0; detCount = 0;
    for (int i = 0; i < 9; i++) begin
      bits  = {bits[30:0], lsbSerOut};
      dones = {dones[30:0], lsbWordDone};
      if (lsbSerValid) begin
        hist = {hist[2:0], lsbSerOut};
        nValid++;
        if (nValid >= 4 && hist == 4'b1010) detCount++;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("lsb_bits", bits, 'h140);
    checkOutput("lsb_done", dones, 'h002);
    checkOutput("lsb_detect_count", 32'(detCount), 1);

    // IDLE_BIT=1 build never receives a word.
    allOne    = 1'b1;
    anyActive = 1'b0;
    for (int i = 0; i < 20; i++) begin
      allOne    = allOne & idlSerOut;
      anyActive = anyActive | idlSerValid | idlBusy | idlWordDone;
      @(posedge clk);
      #1;
    end
    checkOutput("idle1_ser_out", 32'(allOne), 1);
    checkOutput("idle1_inactive", 32'(anyActive), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of each parallel word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select the shift order: 1 = MSB first, 0 = LSB first.
REQ-003 Parameter IDLE_BIT, default 0, SHALL set the level driven on ser_out when no word is being shifted.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 s_valid  input  1  SHALL indicate that upstream presents a word.
REQ-007 s_data  input  DATA_W  SHALL carry the parallel word to serialize.
REQ-008 s_ready  output  1  SHALL indicate that the block can accept a word this cycle.
REQ-009 ser_out  output  1  SHALL carry the serial bit stream that drives the 1010 detector's in port.
REQ-010 ser_valid  output  1  SHALL be high in every cycle in which ser_out carries a data bit.
REQ-011 word_done  output  1  SHALL pulse for one cycle with the last bit of each word.
REQ-012 busy  output  1  SHALL be high when the shifter or the holding register is occupied.

Function
REQ-013 A word SHALL be accepted on a rising edge where s_valid and s_ready are both high; s_data SHALL NOT be sampled at any other time.
REQ-014 Storage SHALL be one shift register plus one holding register; s_ready SHALL equal "holding register empty", registered, with no combinational path from s_valid.
REQ-015 FSM states: IDLE (shifter empty), SHIFT (shifter active); IDLE->SHIFT when a word is present; SHIFT->IDLE after the last bit if the holding register is empty; otherwise SHIFT->SHIFT.
REQ-016 A word accepted in cycle N while IDLE SHALL move straight to the shifter, and its first bit SHALL appear on ser_out in cycle N+1.
REQ-017 Each word SHALL occupy exactly DATA_W consecutive cycles on ser_out, with ser_valid high throughout.
REQ-018 A bit counter of width clog2(DATA_W) SHALL count 0..DATA_W-1 and wrap to 0 when the next word loads; word_done SHALL be high in the cycle the counter equals DATA_W-1.
REQ-019 If the holding register is full when the last bit is output, the held word SHALL load in the next cycle, giving back-to-back words with no gap cycle.
REQ-020 A word accepted in the same cycle as a last-bit/reload event SHALL be written into the holding register that is being freed, and SHALL NOT be lost or duplicated.
REQ-021 When the holding register is full and the shifter is active, s_ready SHALL be low, and upstream s_valid/s_data SHALL be ignored.
REQ-022 In IDLE, ser_out SHALL equal IDLE_BIT and ser_valid, word_done and busy SHALL all be 0.
REQ-023 ser_out, ser_valid and word_done SHALL be driven directly from flops.

Reset
REQ-024 While rst is low, the block SHALL immediately set: state=IDLE, counter=0, both registers empty, ser_out=IDLE_BIT, ser_valid=0, word_done=0, busy=0.
REQ-025 s_ready SHALL be 0 while rst is low and SHALL go to 1 on the first clock edge after rst deasserts.
REQ-026 A reset asserted mid-word SHALL discard the partial word and any held word; no remaining bits SHALL be emitted after release.

Structure
REQ-027 Package seq_pkg SHALL hold the FSM state enum (IDLE, SHIFT), DEFAULT_DATA_W=8 and the clog2-based counter-width function.
REQ-028 Sub-module piso_shift_reg SHALL implement the loadable shift register and its direction selection; the FSM, bit counter and holding register SHALL stay in bit_serializer.

Verification
REQ-029 Reset, then one word 8'hA0 with MSB_FIRST=1 -> ser_out = 1,0,1,0,0,0,0,0 in cycles N+1..N+8, word_done in cycle N+8, then IDLE_BIT.
REQ-030 Back-to-back words 8'hAA then 8'h55 with s_valid held high -> 16 contiguous bits 1010101001010101 with no gap, and s_ready low for exactly one window while the holding register is full.
REQ-031 Three words offered continuously -> the third is accepted only when s_ready rises, the data is not lost or duplicated, and the third word's bits follow the second with no gap.
REQ-032 rst pulsed low after 3 bits of 8'hF0 -> outputs clear immediately, and after release ser_out stays IDLE_BIT with no residual bits.
REQ-033 MSB_FIRST=0, word 8'h05 -> ser_out = 1,0,1,0,0,0,0,0; the downstream detector sees 1010 and asserts its output once.
REQ-034 IDLE_BIT=1, no input -> ser_out stays 1 and ser_valid stays 0 indefinitely.
